// File: rtl/dispatch_scheduler_pkg.sv
// Shared types for the dispatch path: decoded instruction layout, scheduler
// states and reservation-station IDs.
package dispatch_scheduler_pkg;

    localparam logic [2:0] RS_NONE = 3'd0;
    localparam logic [2:0] RS_ALU  = 3'd1;
    localparam logic [2:0] RS_MUL  = 3'd2;
    localparam logic [2:0] RS_BR   = 3'd3;
    localparam logic [2:0] RS_MEM  = 3'd4;

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        GROUP
    } dispatch_state_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic [2:0]  rs_station;
        logic        is_zerocycle;
        logic        reg_reg_mov;
        logic        macroop_start;
        logic        macroop_end;
    } decoded_instruction;

    // Station IDs outside 1..num_stations have nowhere to go, so they retire locally.
    function automatic logic is_zero_cycle(decoded_instruction d, int num_stations);
        return d.is_zerocycle || (d.rs_station == RS_NONE) ||
               (int'(d.rs_station) > num_stations);
    endfunction

endpackage

// File: rtl/dispatch_queue.sv
// In-order circular buffer of decoded instructions with flush and a per-age
// view of which younger entries close a macro-op group.
module dispatch_queue
    import dispatch_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  decoded_instruction           push_instr,
    input  logic                         pop,
    input  logic                         flush,
    output decoded_instruction           head_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DEPTH-2:0]             younger_end
);
    localparam int PW = $clog2(DEPTH);

    decoded_instruction mem [DEPTH];
    logic [PW-1:0]      head_ptr;
    logic [PW-1:0]      tail_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail_ptr] <= push_instr;
    end

    assign head_instr = mem[head_ptr];

    // Bit i-1 reports the entry i positions behind the head.
    always_comb begin
        younger_end = '0;
        for (int i = 1; i < DEPTH; i++) begin
            younger_end[i-1] = (i < int'(count)) && mem[head_ptr + PW'(i)].macroop_end;
        end
    end

endmodule

// File: rtl/dispatch_scheduler.sv
// Dispatches the queue head to one reservation station per cycle, retires
// zero-cycle instructions locally and keeps macro-op groups back to back.
//
//   state | meaning
//   RUN   | normal dispatch; a group start without its end queued moves to HOLD
//   HOLD  | group start at head, waiting for its end entry; nothing dispatches
//   GROUP | group members dispatching; leaves when the end entry pops
module dispatch_scheduler
    import dispatch_scheduler_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int NUM_STATIONS = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    input  decoded_instruction           in_instr,
    output logic                         in_ready,
    output logic [NUM_STATIONS-1:0]      rs_valid,
    output decoded_instruction           rs_instr,
    input  logic [NUM_STATIONS-1:0]      rs_ready,
    output logic                         zc_valid,
    output logic                         zc_mov,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [15:0]                  stall_count
);
    dispatch_state_t    state;
    decoded_instruction head;
    logic [DEPTH-2:0]   younger_end;
    logic               younger_any;
    logic               nonempty;
    logic               head_zc;
    logic               start_only;
    logic               group_wait;
    logic               dispatch_en;
    logic               pop;

    dispatch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (in_valid && in_ready),
        .push_instr  (in_instr),
        .pop         (pop),
        .flush       (flush),
        .head_instr  (head),
        .count       (occupancy),
        .younger_end (younger_end)
    );

    assign in_ready    = int'(occupancy) < DEPTH;
    assign younger_any = |younger_end;
    assign nonempty    = occupancy != '0;
    assign head_zc     = is_zero_cycle(head, NUM_STATIONS);
    assign start_only  = head.macroop_start && !head.macroop_end;
    assign group_wait  = (state == HOLD) || ((state == RUN) && start_only && !younger_any);
    assign dispatch_en = nonempty && !flush && !group_wait;

    always_comb begin
        rs_valid = '0;
        for (int i = 0; i < NUM_STATIONS; i++) begin
            rs_valid[i] = dispatch_en && !head_zc && (int'(head.rs_station) == i + 1);
        end
    end

    assign rs_instr = head;
    assign zc_valid = dispatch_en && head_zc;
    assign zc_mov   = zc_valid && head.reg_reg_mov;
    assign pop      = zc_valid || |(rs_valid & rs_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else if (flush) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (nonempty && start_only) begin
                        if (!younger_any) state <= HOLD;
                        else if (pop)     state <= GROUP;
                    end
                end
                HOLD: begin
                    if (younger_any) state <= RUN;
                end
                GROUP: begin
                    if (pop && head.macroop_end) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (!flush && nonempty && !pop && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler: queue model checked every cycle plus
// hand-computed literal expectations for each scenario.
module tb_dispatch_scheduler;
    import dispatch_scheduler_pkg::*;

    localparam int DEPTH = 4;
    localparam int NS    = 4;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               flush = 1'b0;
    decoded_instruction in_instr = '0;
    logic [NS-1:0]      rs_ready = '0;
    logic               in_ready;
    logic [NS-1:0]      rs_valid;
    decoded_instruction rs_instr;
    logic               zc_valid;
    logic               zc_mov;
    logic [2:0]         occupancy;
    logic [15:0]        stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dispatch_scheduler #(.DEPTH(DEPTH), .NUM_STATIONS(NS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .rs_valid    (rs_valid),
        .rs_instr    (rs_instr),
        .rs_ready    (rs_ready),
        .zc_valid    (zc_valid),
        .zc_mov      (zc_mov),
        .flush       (flush),
        .occupancy   (occupancy),
        .stall_count (stall_count)
    );

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic decoded_instruction mk(logic [5:0] op, logic [2:0] st, bit zc,
                                              bit mv, bit s, bit e);
        decoded_instruction d;
        d = '0;
        d.opcode        = op;
        d.rd            = 5'(op + 6'd3);
        d.rs            = 5'(op + 6'd1);
        d.rt            = 5'(op + 6'd2);
        d.imm           = {10'h2A5, op};
        d.rs_station    = st;
        d.is_zerocycle  = zc;
        d.reg_reg_mov   = mv;
        d.macroop_start = s;
        d.macroop_end   = e;
        return d;
    endfunction

    // Reference model: queue contents, group bookkeeping, stall counter.
    decoded_instruction mq[$];
    bit m_wait;
    bit m_grp;
    int m_stall;

    function automatic bit end_after_head();
        for (int i = 1; i < mq.size(); i++) if (mq[i].macroop_end) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit retires_locally(decoded_instruction d);
        return d.is_zerocycle || d.rs_station == 3'd0 || int'(d.rs_station) > NS;
    endfunction

    always @(negedge clk) begin
        decoded_instruction h;
        bit disp, blocked, hz, popped, e_ready;
        logic [NS-1:0] e_rs;
        if (!reset_n) begin
            mq.delete();
            m_wait  = 1'b0;
            m_grp   = 1'b0;
            m_stall = 0;
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_rs_valid", 64'(rs_valid), 64'd0);
            check("rst_zc_valid", 64'(zc_valid), 64'd0);
            check("rst_occupancy", 64'(occupancy), 64'd0);
            check("rst_stall", 64'(stall_count), 64'd0);
        end else begin
            h       = '0;
            disp    = 1'b0;
            blocked = 1'b0;
            hz      = 1'b0;
            e_rs    = '0;
            if (mq.size() > 0) h = mq[0];
            if (!flush && mq.size() > 0) begin
                hz = retires_locally(h);
                if (m_wait || (!m_grp && h.macroop_start && !h.macroop_end && !end_after_head()))
                    blocked = 1'b1;
                else
                    disp = 1'b1;
            end
            if (disp && !hz) e_rs = NS'(1) << (int'(h.rs_station) - 1);
            popped  = disp && (hz || |(e_rs & rs_ready));
            e_ready = mq.size() < DEPTH;
            check("m_in_ready", 64'(in_ready), 64'(e_ready));
            check("m_occupancy", 64'(occupancy), 64'(mq.size()));
            check("m_stall", 64'(stall_count), 64'(m_stall));
            check("m_rs_valid", 64'(rs_valid), 64'(e_rs));
            check("m_zc_valid", 64'(zc_valid), 64'(disp && hz));
            check("m_zc_mov", 64'(zc_mov), 64'(disp && hz && h.reg_reg_mov));
            if (e_rs != '0) check("m_rs_instr", 64'(rs_instr), 64'(h));
            if (flush) begin
                mq.delete();
                m_wait = 1'b0;
                m_grp  = 1'b0;
            end else begin
                if (mq.size() > 0 && !popped && m_stall < 65535) m_stall++;
                if (m_wait) m_wait = !end_after_head();
                else        m_wait = blocked;
                if (popped) begin
                    if (h.macroop_end)        m_grp = 1'b0;
                    else if (h.macroop_start) m_grp = 1'b1;
                    void'(mq.pop_front());
                end
                if (in_valid && e_ready) mq.push_back(in_instr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset_n = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        rs_ready = '0;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    decoded_instruction addiu, andi, noop, mov, lw, g0, g1, g2, mul;
    decoded_instruction mix [6];

    initial begin
        addiu = mk(6'h09, RS_ALU, 0, 0, 0, 0);
        andi  = mk(6'h0C, RS_ALU, 0, 0, 0, 0);
        noop  = mk(6'h00, RS_NONE, 1, 0, 0, 0);
        mov   = mk(6'h21, RS_ALU, 1, 1, 0, 0);
        lw    = mk(6'h23, RS_MEM, 0, 0, 0, 0);
        mul   = mk(6'h1C, RS_MUL, 0, 0, 0, 0);
        g0    = mk(6'h10, RS_ALU, 0, 0, 1, 0);
        g1    = mk(6'h11, RS_MUL, 0, 0, 0, 0);
        g2    = mk(6'h12, RS_BR,  0, 0, 0, 1);
        mix[0] = mk(6'h01, RS_ALU, 0, 0, 0, 0);
        mix[1] = mk(6'h02, RS_MUL, 0, 0, 0, 0);
        mix[2] = mk(6'h03, 3'd7,   0, 0, 0, 0);
        mix[3] = mk(6'h04, RS_BR,  0, 0, 1, 1);
        mix[4] = mk(6'h05, RS_MEM, 0, 0, 0, 0);
        mix[5] = mk(6'h06, RS_NONE, 1, 1, 0, 0);

        #16 reset_n = 1'b1;

        // Back-to-back ALU dispatch
        rs_ready = 4'b0001;
        in_valid = 1'b1;
        in_instr = addiu;
        step();
        in_instr = andi;
        #1 check("t1_rs_valid0", 64'(rs_valid), 64'h1);
        check("t1_rs_instr0", 64'(rs_instr), 64'(addiu));
        step();
        in_valid = 1'b0;
        #1 check("t1_rs_valid1", 64'(rs_valid), 64'h1);
        check("t1_rs_instr1", 64'(rs_instr), 64'(andi));
        step();
        #1 check("t1_occ", 64'(occupancy), 64'd0);
        check("t1_idle", 64'(rs_valid), 64'd0);

        // Zero-cycle retire
        in_valid = 1'b1;
        in_instr = noop;
        step();
        in_instr = mov;
        #1 check("t2_zc0", 64'({zc_valid, zc_mov}), 64'b10);
        check("t2_rs0", 64'(rs_valid), 64'd0);
        step();
        in_valid = 1'b0;
        #1 check("t2_zc1", 64'({zc_valid, zc_mov}), 64'b11);
        check("t2_rs1", 64'(rs_valid), 64'd0);
        step();
        #1 check("t2_zc_done", 64'(zc_valid), 64'd0);

        // Fill and stall on MEM station
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_instr = lw;
            step();
        end
        #1 check("t3_full_occ", 64'(occupancy), 64'd4);
        check("t3_in_ready", 64'(in_ready), 64'd0);
        check("t3_stall3", 64'(stall_count), 64'd3);
        repeat (7) step();
        in_valid = 1'b0;
        rs_ready = 4'b1000;
        #1 check("t3_stall10", 64'(stall_count), 64'd10);
        check("t3_occ4", 64'(occupancy), 64'd4);
        check("t3_rs_mem", 64'(rs_valid), 64'h8);
        repeat (3) step();
        #1 check("t3_occ1", 64'(occupancy), 64'd1);
        step();
        #1 check("t3_drained", 64'(occupancy), 64'd0);
        check("t3_stall_kept", 64'(stall_count), 64'd10);

        // Macro-op group held until its end entry arrives
        do_reset();
        rs_ready = 4'b1111;
        in_valid = 1'b1;
        in_instr = g0;
        step();
        in_valid = 1'b0;
        #1 check("t4_hold0", 64'(rs_valid), 64'd0);
        step();
        #1 check("t4_hold1", 64'(rs_valid), 64'd0);
        step();
        in_valid = 1'b1;
        in_instr = g1;
        #1 check("t4_hold2", 64'(rs_valid), 64'd0);
        step();
        in_instr = g2;
        #1 check("t4_hold3", 64'(rs_valid), 64'd0);
        step();
        in_valid = 1'b0;
        #1 check("t4_hold4", 64'(rs_valid), 64'd0);
        step();
        #1 check("t4_g0", 64'(rs_valid), 64'h1);
        step();
        #1 check("t4_g1", 64'(rs_valid), 64'h2);
        step();
        #1 check("t4_g2", 64'(rs_valid), 64'h4);
        step();
        #1 check("t4_empty", 64'(occupancy), 64'd0);
        check("t4_stall", 64'(stall_count), 64'd5);

        // Flush drops queue and the flush-cycle input
        do_reset();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_instr = mul;
            step();
        end
        in_instr = addiu;
        flush = 1'b1;
        #1 check("t5_flush_rs", 64'(rs_valid), 64'd0);
        check("t5_flush_zc", 64'(zc_valid), 64'd0);
        check("t5_flush_ready", 64'(in_ready), 64'd1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1 check("t5_occ0", 64'(occupancy), 64'd0);
        check("t5_stall", 64'(stall_count), 64'd2);

        // Mixed stream with partial station readiness
        rs_ready = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_instr = mix[k];
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        rs_ready = 4'b1111;
        repeat (8) step();
        #1 check("t6_empty", 64'(occupancy), 64'd0);

        // Saturation and asynchronous reset
        do_reset();
        in_valid = 1'b1;
        in_instr = lw;
        step();
        in_valid = 1'b0;
        repeat (65540) step();
        #1 check("t7_sat", 64'(stall_count), 64'hFFFF);
        check("t7_occ", 64'(occupancy), 64'd1);
        in_valid = 1'b1;
        in_instr = addiu;
        #1 reset_n = 1'b0;
        #1 check("t7_arst_ready", 64'(in_ready), 64'd1);
        check("t7_arst_rs", 64'(rs_valid), 64'd0);
        check("t7_arst_zc", 64'({zc_valid, zc_mov}), 64'd0);
        check("t7_arst_occ", 64'(occupancy), 64'd0);
        check("t7_arst_stall", 64'(stall_count), 64'd0);
        in_valid = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
